// File: rtl/tcm_sig_pkg.sv
// rtl/tcm_sig_pkg.sv - shared types, constants and helpers for the TCM signature dumper
package tcm_sig_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [7:0] NL_CHAR_DEFAULT = 8'h0A;

    // Lowercase ASCII hex digit for one nibble
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/tcm_sig_dump_ser.sv
// rtl/tcm_sig_dump_ser.sv - 9-char word serializer: 8 hex digits MSB first, then line terminator
module sig_hex_ser
    import tcm_sig_pkg::*;
#(
    parameter logic [7:0] NL_CHAR = NL_CHAR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic        valid_o,
    output logic [7:0]  data_o,
    input  logic        ready_i,
    output logic        last_o
);

    logic [31:0] word_q, word_d;
    logic [3:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [31:0] word_sh;

    // Next-state: a load restarts the word; each accepted char advances, the terminator ends it
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            idx_d   = 4'd0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (idx_q == 4'd8) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // Serializer state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Current char; forced to zero while idle so the byte bus is quiet outside a word
    always_comb begin
        word_sh = word_q << {idx_q[2:0], 2'b00};
        data_o  = 8'h00;
        if (valid_q) begin
            data_o = (idx_q == 4'd8) ? NL_CHAR : nib2ascii(word_sh[31:28]);
        end
        valid_o = valid_q;
        last_o  = valid_q && (idx_q == 4'd8);
    end

endmodule

// File: rtl/tcm_sig_dump.sv
// rtl/tcm_sig_dump.sv - dumps a word range of TCM as ASCII hex lines over a byte stream
module tcm_sig_dump
    import tcm_sig_pkg::*;
#(
    parameter logic [7:0] NL_CHAR = NL_CHAR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] begin_addr_i,
    input  logic [31:0] end_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] end_q, end_d;
    logic        err_q, err_d;
    logic        range_bad;
    logic        ser_load;
    logic        ser_last;
    logic [32:0] addr_next;

    // Next-state and read/serializer control; one read in flight at most
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        err_d     = err_q;
        ser_load  = 1'b0;
        range_bad = (begin_addr_i[1:0] != 2'b00) || (end_addr_i[1:0] != 2'b00)
                    || (begin_addr_i > end_addr_i);
        addr_next = {1'b0, addr_q} + 33'd4;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d = begin_addr_i;
                    end_d  = end_addr_i;
                    err_d  = range_bad;
                    if (range_bad || (begin_addr_i == end_addr_i)) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_accept_i) begin
                    if (mem_ack_i) begin
                        ser_load = 1'b1;
                        state_d  = SEND;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    ser_load = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (ser_last && tx_ready_i) begin
                    // A carry out means the next address would wrap; stop instead
                    if (!addr_next[32] && (addr_next[31:0] < end_q)) begin
                        addr_d  = addr_next[31:0];
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any read or word in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    // Status and read-port outputs decoded from the registered state
    always_comb begin
        busy_o     = (state_q == REQ) || (state_q == WAIT) || (state_q == SEND);
        done_o     = (state_q == DONE);
        err_o      = (state_q == DONE) && err_q;
        mem_rd_o   = (state_q == REQ);
        mem_addr_o = addr_q;
    end

    sig_hex_ser #(
        .NL_CHAR (NL_CHAR)
    ) u_ser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (ser_load),
        .word_i  (mem_data_i),
        .valid_o (tx_valid_o),
        .data_o  (tx_data_o),
        .ready_i (tx_ready_i),
        .last_o  (ser_last)
    );

endmodule

// File: tb/tb_tcm_sig_dump.sv
// tb/tb_tcm_sig_dump.sv - directed self-checking bench for tcm_sig_dump
module tb_tcm_sig_dump;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] begin_addr_i = '0;
    logic [31:0] end_addr_i = '0;
    logic        busy_o, done_o, err_o, mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i, mem_ack_i;
    logic [31:0] mem_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;

    int checks = 0;
    int errors = 0;

    int acc_dly = 0;
    int ack_dly = 0;
    bit rdy_tog = 1'b0;
    int inj_req = 0;
    int inj_seen = 0;

    logic [31:0] rd_addrs[$];
    logic [7:0]  rx[$];
    int          done_cnt = 0;
    int          stab_viol = 0;
    logic        rd_hold = 1'b0, tx_hold = 1'b0;
    logic [31:0] rd_addr_prev = '0;
    logic [7:0]  tx_prev = '0;

    tcm_sig_dump dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .begin_addr_i (begin_addr_i),
        .end_addr_i   (end_addr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_accept_i (mem_accept_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0104: return 32'h0000_0001;
            32'hFFFF_FFF8: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Memory responder with programmable accept / ack latency
    initial begin
        logic [31:0] a;
        mem_accept_i = 1'b0;
        mem_ack_i    = 1'b0;
        mem_data_i   = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            mem_accept_i = 1'b0;
            mem_ack_i    = 1'b0;
            mem_data_i   = 32'h5A5A_5A5A;
            if (inj_req != inj_seen) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 32'hBAD0_BAD0;
                inj_seen   = inj_req;
            end else if (mem_rd_o) begin
                repeat (acc_dly) @(negedge clk);
                a = mem_addr_o;
                rd_addrs.push_back(a);
                mem_accept_i = 1'b1;
                if (ack_dly == 0) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = memf(a);
                end else begin
                    @(negedge clk);
                    mem_accept_i = 1'b0;
                    repeat (ack_dly - 1) @(negedge clk);
                    mem_ack_i  = 1'b1;
                    mem_data_i = memf(a);
                end
            end
        end
    end

    // Byte-stream sink ready
    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            tx_ready_i = rdy_tog ? ~tx_ready_i : 1'b1;
        end
    end

    // Monitor: captured bytes, done pulses, hold-stability of stalled outputs
    always @(posedge clk) begin
        if (!rst_i) begin
            if (tx_valid_o && tx_ready_i) rx.push_back(tx_data_o);
            if (done_o) done_cnt <= done_cnt + 1;
            if (rd_hold && (!mem_rd_o || mem_addr_o != rd_addr_prev)) stab_viol <= stab_viol + 1;
            if (tx_hold && (!tx_valid_o || tx_data_o != tx_prev)) stab_viol <= stab_viol + 1;
        end
        rd_hold      <= !rst_i && mem_rd_o && !mem_accept_i;
        rd_addr_prev <= mem_addr_o;
        tx_hold      <= !rst_i && tx_valid_o && !tx_ready_i;
        tx_prev      <= tx_data_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag, input int base, input string exp);
        chk({tag, "_len"}, 64'(rx.size() - base), 64'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (base + i < rx.size()) chk(tag, {56'h0, rx[base + i]}, {56'h0, exp[i]});
        end
    endtask

    task automatic start_dump(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        begin_addr_i = b;
        end_addr_i   = e;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        begin_addr_i = 32'hFFFF_FFFF;
        end_addr_i   = 32'h0;
    endtask

    task automatic wait_done(output logic got_err);
        int n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {63'h0, done_o}, 64'h1);
        got_err = err_o;
    endtask

    initial begin
        logic e;
        int   base, rd0, dc0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy_o}, 0);
        chk("rst_done", {63'h0, done_o}, 0);
        chk("rst_err", {63'h0, err_o}, 0);
        chk("rst_rd", {63'h0, mem_rd_o}, 0);
        chk("rst_addr", {32'h0, mem_addr_o}, 0);
        chk("rst_txv", {63'h0, tx_valid_o}, 0);
        chk("rst_txd", {56'h0, tx_data_o}, 0);
        rst_i = 1'b0;

        // Two-word dump, always-ready sink
        base = rx.size(); rd0 = rd_addrs.size(); dc0 = done_cnt;
        start_dump(32'h100, 32'h108);
        chk("t1_busy", {63'h0, busy_o}, 1);
        chk("t1_rd", {63'h0, mem_rd_o}, 1);
        chk("t1_addr", {32'h0, mem_addr_o}, 64'h100);
        wait_done(e);
        chk("t1_err", {63'h0, e}, 0);
        chk("t1_busy_done", {63'h0, busy_o}, 0);
        chk_bytes("t1_bytes", base, "deadbeef\n00000001\n");
        chk("t1_nrd", 64'(rd_addrs.size() - rd0), 2);
        @(negedge clk);
        chk("t1_done_1cyc", {63'h0, done_o}, 0);
        chk("t1_done_cnt", 64'(done_cnt - dc0), 1);

        // Empty range: done right after the start cycle, no read, no bytes
        base = rx.size(); rd0 = rd_addrs.size();
        start_dump(32'h200, 32'h200);
        chk("t2_done", {63'h0, done_o}, 1);
        chk("t2_err", {63'h0, err_o}, 0);
        chk("t2_busy", {63'h0, busy_o}, 0);
        repeat (2) @(negedge clk);
        chk("t2_nrd", 64'(rd_addrs.size() - rd0), 0);
        chk("t2_nbytes", 64'(rx.size() - base), 0);

        // Rejected ranges: misaligned begin, begin beyond end
        rd0 = rd_addrs.size();
        start_dump(32'h102, 32'h200);
        chk("t3a_done", {63'h0, done_o}, 1);
        chk("t3a_err", {63'h0, err_o}, 1);
        start_dump(32'h110, 32'h100);
        chk("t3b_done", {63'h0, done_o}, 1);
        chk("t3b_err", {63'h0, err_o}, 1);
        repeat (2) @(negedge clk);
        chk("t3_nrd", 64'(rd_addrs.size() - rd0), 0);

        // Slow memory, toggling sink, plus a start pulse while busy
        acc_dly = 3; ack_dly = 5; rdy_tog = 1'b1;
        base = rx.size(); rd0 = rd_addrs.size(); dc0 = done_cnt;
        start_dump(32'h100, 32'h108);
        repeat (4) @(negedge clk);
        begin_addr_i = 32'h400; end_addr_i = 32'h404; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(e);
        chk("t4_err", {63'h0, e}, 0);
        chk_bytes("t4_bytes", base, "deadbeef\n00000001\n");
        repeat (4) @(negedge clk);
        chk("t4_nrd", 64'(rd_addrs.size() - rd0), 2);
        chk("t4_done_cnt", 64'(done_cnt - dc0), 1);
        chk("t4_stable", 64'(stab_viol), 0);
        acc_dly = 0; ack_dly = 0; rdy_tog = 1'b0;
        @(negedge clk);

        // Reset mid-word, stray ack afterwards, then a clean dump
        base = rx.size();
        start_dump(32'h100, 32'h108);
        for (int n = 0; n < 200 && (rx.size() - base) < 4; n++) @(negedge clk);
        chk("t5_four", 64'(rx.size() - base), 4);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("t5_busy", {63'h0, busy_o}, 0);
        chk("t5_txv", {63'h0, tx_valid_o}, 0);
        chk("t5_txd", {56'h0, tx_data_o}, 0);
        chk("t5_rd", {63'h0, mem_rd_o}, 0);
        chk("t5_addr", {32'h0, mem_addr_o}, 0);
        chk("t5_done", {63'h0, done_o}, 0);
        inj_req++;
        repeat (4) @(negedge clk);
        chk("t5_late_txv", {63'h0, tx_valid_o}, 0);
        chk("t5_late_busy", {63'h0, busy_o}, 0);
        chk("t5_late_bytes", 64'(rx.size() - base), 4);
        base = rx.size();
        start_dump(32'h100, 32'h108);
        wait_done(e);
        chk("t5_err", {63'h0, e}, 0);
        chk_bytes("t5_bytes", base, "deadbeef\n00000001\n");

        // Top-of-memory word: one read, no wrap
        base = rx.size(); rd0 = rd_addrs.size();
        start_dump(32'hFFFF_FFF8, 32'hFFFF_FFFC);
        wait_done(e);
        chk("t6_err", {63'h0, e}, 0);
        chk_bytes("t6_bytes", base, "12345678\n");
        repeat (3) @(negedge clk);
        chk("t6_nrd", 64'(rd_addrs.size() - rd0), 1);
        if (rd_addrs.size() > rd0) chk("t6_addr", {32'h0, rd_addrs[rd0]}, 64'hFFFF_FFF8);
        rd0 = rd_addrs.size();
        start_dump(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("t6b_done", {63'h0, done_o}, 1);
        chk("t6b_err", {63'h0, err_o}, 0);
        repeat (2) @(negedge clk);
        chk("t6b_nrd", 64'(rd_addrs.size() - rd0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
